id_stage: RTL and testbench

- Instruction-decode stage of the RV32I pipeline.
- Sits between the IF/ID handoff and EX, and drives the regfile read ports combinationally.
- Decodes the fetched word, selects operands and builds the immediate.
- Detects load-use hazards and inserts a one-cycle bubble.
- Registers the result into an ID/EX pipeline register with a valid/ready handshake.

---
 rtl/id_stage.sv | 188 ++++++++++++++++++
 tb/tb_id_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: decodes the IF word, reads the regfile, builds
// operands/immediate, inserts a load-use bubble and registers the result into ID/EX.
module id_stage #(
  parameter int XLEN            = 32,
  parameter bit LOAD_USE_BUBBLE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  input  logic            flush,
  output logic            rs1pass,
  output logic [4:0]      rs1addr,
  output logic            rs2pass,
  output logic [4:0]      rs2addr,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic [XLEN-1:0] ex_rs2val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic            ex_we,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_alt,
  output logic            ex_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] dec_imm, dec_op1, dec_op2;
  logic            dec_we_raw, dec_we, dec_alt, dec_illegal;
  logic            use_rs1, use_rs2;
  logic            hazard;

  assign opcode  = in_inst[6:0];
  assign rd      = in_inst[11:7];
  assign funct3  = in_inst[14:12];
  assign rs1addr = in_inst[19:15];
  assign rs2addr = in_inst[24:20];

  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  // Per-opcode operand selection; unrecognised opcodes fall to zeroed operands.
  always_comb begin
    dec_imm     = '0;
    dec_op1     = rs1;
    dec_op2     = '0;
    dec_we_raw  = 1'b0;
    dec_alt     = 1'b0;
    dec_illegal = 1'b0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec_imm    = imm_u;
        dec_op1    = '0;
        dec_op2    = imm_u;
        dec_we_raw = 1'b1;
      end
      OPC_AUIPC: begin
        dec_imm    = imm_u;
        dec_op1    = in_pc;
        dec_op2    = imm_u;
        dec_we_raw = 1'b1;
      end
      OPC_JAL: begin
        dec_imm    = imm_j;
        dec_op1    = in_pc;
        dec_op2    = XLEN'(4);
        dec_we_raw = 1'b1;
      end
      OPC_JALR: begin
        dec_imm    = imm_i;
        dec_op2    = XLEN'(4);
        dec_we_raw = 1'b1;
        use_rs1    = 1'b1;
      end
      OPC_BRANCH: begin
        dec_imm = imm_b;
        dec_op2 = rs2;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        dec_imm    = imm_i;
        dec_op2    = imm_i;
        dec_we_raw = 1'b1;
        use_rs1    = 1'b1;
      end
      OPC_STORE: begin
        dec_imm = imm_s;
        dec_op2 = imm_s;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_OPIMM: begin
        dec_imm    = imm_i;
        dec_op2    = imm_i;
        dec_we_raw = 1'b1;
        dec_alt    = (funct3 == 3'b101) & in_inst[30];
        use_rs1    = 1'b1;
      end
      OPC_OP: begin
        dec_op2    = rs2;
        dec_we_raw = 1'b1;
        dec_alt    = in_inst[30];
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
      end
      default: begin
        dec_op1     = '0;
        dec_illegal = 1'b1;
      end
    endcase
  end

  assign dec_we  = dec_we_raw & (rd != 5'd0);
  assign rs1pass = in_valid & use_rs1;
  assign rs2pass = in_valid & use_rs2;

  // A load still sitting in ID/EX cannot forward to its direct consumer yet.
  assign hazard = LOAD_USE_BUBBLE && ex_valid && (ex_opcode == OPC_LOAD) && (ex_rd != 5'd0) &&
                  ((rs1pass && (rs1addr == ex_rd)) || (rs2pass && (rs2addr == ex_rd)));

  assign in_ready = (~ex_valid | ex_ready) & ~hazard & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_op1     <= '0;
      ex_op2     <= '0;
      ex_rs2val  <= '0;
      ex_imm     <= '0;
      ex_rd      <= '0;
      ex_we      <= 1'b0;
      ex_opcode  <= '0;
      ex_funct3  <= '0;
      ex_alt     <= 1'b0;
      ex_illegal <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (ex_valid && !ex_ready) begin
      ex_valid <= ex_valid;
    end else if (hazard) begin
      ex_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      ex_valid   <= 1'b1;
      ex_pc      <= in_pc;
      ex_op1     <= dec_op1;
      ex_op2     <= dec_op2;
      ex_rs2val  <= rs2;
      ex_imm     <= dec_imm;
      ex_rd      <= rd;
      ex_we      <= dec_we;
      ex_opcode  <= opcode;
      ex_funct3  <= funct3;
      ex_alt     <= dec_alt;
      ex_illegal <= dec_illegal;
    end else begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode vectors, backpressure hold, async reset,
// load-use bubble (with and without bubbling) and flush.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, ex_ready;
  logic [31:0] in_pc, in_inst, rs1, rs2;

  logic        in_ready, rs1pass, rs2pass, ex_valid, ex_we, ex_alt, ex_illegal;
  logic [4:0]  rs1addr, rs2addr, ex_rd;
  logic [31:0] ex_pc, ex_op1, ex_op2, ex_rs2val, ex_imm;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;

  logic        nb_in_ready, nb_rs1pass, nb_rs2pass, nb_ex_valid, nb_ex_we, nb_ex_alt, nb_ex_illegal;
  logic [4:0]  nb_rs1addr, nb_rs2addr, nb_ex_rd;
  logic [31:0] nb_ex_pc, nb_ex_op1, nb_ex_op2, nb_ex_rs2val, nb_ex_imm;
  logic [6:0]  nb_ex_opcode;
  logic [2:0]  nb_ex_funct3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_stage #(.XLEN(32), .LOAD_USE_BUBBLE(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .flush(flush), .rs1pass(rs1pass), .rs1addr(rs1addr),
    .rs2pass(rs2pass), .rs2addr(rs2addr), .rs1(rs1), .rs2(rs2), .ex_valid(ex_valid),
    .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_rs2val(ex_rs2val), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_we(ex_we),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_alt(ex_alt), .ex_illegal(ex_illegal)
  );

  id_stage #(.XLEN(32), .LOAD_USE_BUBBLE(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nb_in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .flush(flush), .rs1pass(nb_rs1pass), .rs1addr(nb_rs1addr),
    .rs2pass(nb_rs2pass), .rs2addr(nb_rs2addr), .rs1(rs1), .rs2(rs2), .ex_valid(nb_ex_valid),
    .ex_ready(ex_ready), .ex_pc(nb_ex_pc), .ex_op1(nb_ex_op1), .ex_op2(nb_ex_op2),
    .ex_rs2val(nb_ex_rs2val), .ex_imm(nb_ex_imm), .ex_rd(nb_ex_rd), .ex_we(nb_ex_we),
    .ex_opcode(nb_ex_opcode), .ex_funct3(nb_ex_funct3), .ex_alt(nb_ex_alt), .ex_illegal(nb_ex_illegal)
  );

  typedef struct packed {
    logic [31:0] pc, inst, r1, r2, op1, op2, imm;
    logic [4:0]  rd;
    logic        we, alt, ill, p1, p2;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic rdy, input logic fl);
    in_valid = v;
    in_pc    = pc;
    in_inst  = inst;
    rs1      = r1;
    rs2      = r2;
    ex_ready = rdy;
    flush    = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //              pc        inst          r1            r2       op1           op2           imm         rd  we alt ill p1 p2
    vecs[0]  = '{32'h100, 32'h00500093, 32'h0,        32'h0,  32'h0,        32'h5,        32'h5,        5'd1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{32'h104, 32'hFFF08093, 32'h7,        32'h0,  32'h7,        32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{32'h200, 32'h123453B7, 32'h55,       32'h66, 32'h0,        32'h12345000, 32'h12345000, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'h204, 32'h0000007F, 32'h55,       32'h66, 32'h0,        32'h0,        32'h0,        5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{32'h208, 32'h0020A423, 32'h1000,     32'hAB, 32'h1000,     32'h8,        32'h8,        5'd8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{32'h20C, 32'hFE208EE3, 32'h3,        32'h4,  32'h3,        32'h4,        32'hFFFFFFFC, 5'd29, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{32'h210, 32'h008000EF, 32'h11,       32'h22, 32'h210,      32'h4,        32'h8,        5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32'h214, 32'h402081B3, 32'hA,        32'h3,  32'hA,        32'h3,        32'h0,        5'd3,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{32'h218, 32'h4030D093, 32'h80000000, 32'h0,  32'h80000000, 32'h403,      32'h403,      5'd1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{32'h21C, 32'h00000013, 32'h0,        32'h0,  32'h0,        32'h0,        32'h0,        5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{32'h220, 32'h00001117, 32'h9,        32'h9,  32'h220,      32'h1000,     32'h1000,     5'd2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{32'h224, 32'h004280E7, 32'h300,      32'h0,  32'h300,      32'h4,        32'h4,        5'd1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("reset.ex_valid", {31'b0, ex_valid}, 32'h0);
    checkOutput("reset.ex_op1", ex_op1, 32'h0);
    rst = 1'b0;

    // decode vectors, each issued into a free register
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, vecs[i].pc, vecs[i].inst, vecs[i].r1, vecs[i].r2, 1'b1, 1'b0);
      #1;
      checkOutput($sformatf("v%0d.rs1pass", i), {31'b0, rs1pass}, {31'b0, vecs[i].p1});
      checkOutput($sformatf("v%0d.rs2pass", i), {31'b0, rs2pass}, {31'b0, vecs[i].p2});
      checkOutput($sformatf("v%0d.in_ready", i), {31'b0, in_ready}, 32'h1);
      tick();
      checkOutput($sformatf("v%0d.ex_valid", i), {31'b0, ex_valid}, 32'h1);
      checkOutput($sformatf("v%0d.ex_pc", i), ex_pc, vecs[i].pc);
      checkOutput($sformatf("v%0d.ex_op1", i), ex_op1, vecs[i].op1);
      checkOutput($sformatf("v%0d.ex_op2", i), ex_op2, vecs[i].op2);
      checkOutput($sformatf("v%0d.ex_imm", i), ex_imm, vecs[i].imm);
      checkOutput($sformatf("v%0d.ex_rs2val", i), ex_rs2val, vecs[i].r2);
      checkOutput($sformatf("v%0d.ex_rd", i), {27'b0, ex_rd}, {27'b0, vecs[i].rd});
      checkOutput($sformatf("v%0d.ex_we", i), {31'b0, ex_we}, {31'b0, vecs[i].we});
      checkOutput($sformatf("v%0d.ex_alt", i), {31'b0, ex_alt}, {31'b0, vecs[i].alt});
      checkOutput($sformatf("v%0d.ex_illegal", i), {31'b0, ex_illegal}, {31'b0, vecs[i].ill});
      checkOutput($sformatf("v%0d.ex_opcode", i), {25'b0, ex_opcode}, {25'b0, vecs[i].inst[6:0]});
      checkOutput($sformatf("v%0d.ex_funct3", i), {29'b0, ex_funct3}, {29'b0, vecs[i].inst[14:12]});
    end

    // add x3,x1,x2 then three cycles of backpressure
    applyStimulus(1'b1, 32'h240, 32'h002081B3, 32'h7, 32'h9, 1'b1, 1'b0);
    #1;
    checkOutput("add.rs1pass", {31'b0, rs1pass}, 32'h1);
    checkOutput("add.rs2pass", {31'b0, rs2pass}, 32'h1);
    tick();
    checkOutput("add.ex_op1", ex_op1, 32'h7);
    checkOutput("add.ex_op2", ex_op2, 32'h9);
    checkOutput("add.ex_alt", {31'b0, ex_alt}, 32'h0);
    applyStimulus(1'b1, 32'h300, 32'h00500093, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput($sformatf("hold%0d.in_ready", c), {31'b0, in_ready}, 32'h0);
      tick();
      checkOutput($sformatf("hold%0d.ex_valid", c), {31'b0, ex_valid}, 32'h1);
      checkOutput($sformatf("hold%0d.ex_op1", c), ex_op1, 32'h7);
      checkOutput($sformatf("hold%0d.ex_op2", c), ex_op2, 32'h9);
      checkOutput($sformatf("hold%0d.ex_pc", c), ex_pc, 32'h240);
    end
    ex_ready = 1'b1;
    #1;
    checkOutput("release.in_ready", {31'b0, in_ready}, 32'h1);
    tick();
    checkOutput("release.ex_pc", ex_pc, 32'h300);
    checkOutput("release.ex_op1", ex_op1, 32'hDEAD);

    // asynchronous reset while ex_valid = 1
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst.ex_valid", {31'b0, ex_valid}, 32'h0);
    checkOutput("arst.ex_pc", ex_pc, 32'h0);
    checkOutput("arst.ex_op1", ex_op1, 32'h0);
    checkOutput("arst.ex_op2", ex_op2, 32'h0);
    checkOutput("arst.ex_imm", ex_imm, 32'h0);
    checkOutput("arst.ex_rd", {27'b0, ex_rd}, 32'h0);
    checkOutput("arst.ex_we", {31'b0, ex_we}, 32'h0);
    checkOutput("arst.ex_opcode", {25'b0, ex_opcode}, 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    rst = 1'b0;

    // lw x5,0(x1) then add x6,x5,x5
    applyStimulus(1'b1, 32'h500, 32'h0000A283, 32'h40, 32'h0, 1'b1, 1'b0);
    #1;
    checkOutput("lw.in_ready", {31'b0, in_ready}, 32'h1);
    tick();
    checkOutput("lw.ex_valid", {31'b0, ex_valid}, 32'h1);
    checkOutput("lw.ex_rd", {27'b0, ex_rd}, 32'd5);
    checkOutput("lw.ex_op1", ex_op1, 32'h40);
    applyStimulus(1'b1, 32'h504, 32'h00528333, 32'h11, 32'h11, 1'b1, 1'b0);
    #1;
    checkOutput("lu.in_ready_stall", {31'b0, in_ready}, 32'h0);
    checkOutput("lu.nb_in_ready", {31'b0, nb_in_ready}, 32'h1);
    tick();
    checkOutput("lu.ex_valid_bubble", {31'b0, ex_valid}, 32'h0);
    checkOutput("lu.nb_ex_valid", {31'b0, nb_ex_valid}, 32'h1);
    checkOutput("lu.nb_ex_rd", {27'b0, nb_ex_rd}, 32'd6);
    checkOutput("lu.in_ready_after", {31'b0, in_ready}, 32'h1);
    tick();
    checkOutput("lu.ex_valid_issue", {31'b0, ex_valid}, 32'h1);
    checkOutput("lu.ex_rd", {27'b0, ex_rd}, 32'd6);
    checkOutput("lu.ex_pc", ex_pc, 32'h504);
    checkOutput("lu.ex_opcode", {25'b0, ex_opcode}, 32'h33);

    // flush with a valid register and a pending instruction
    applyStimulus(1'b1, 32'h600, 32'h00500093, 32'h0, 32'h0, 1'b1, 1'b1);
    #1;
    checkOutput("flush.in_ready", {31'b0, in_ready}, 32'h0);
    tick();
    checkOutput("flush.ex_valid", {31'b0, ex_valid}, 32'h0);
    applyStimulus(1'b1, 32'h604, 32'h00500093, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("refill.ex_valid", {31'b0, ex_valid}, 32'h1);
    checkOutput("refill.ex_pc", ex_pc, 32'h604);
    applyStimulus(1'b1, 32'h608, 32'h00500093, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    checkOutput("flush_stalled.ex_valid", {31'b0, ex_valid}, 32'h0);
    applyStimulus(1'b0, 32'h60C, 32'h00500093, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    checkOutput("idle.rs1pass", {31'b0, rs1pass}, 32'h0);
    tick();
    checkOutput("idle.ex_valid", {31'b0, ex_valid}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
